// File: rtl/enoc_link_pipe.sv
// enoc_link_pipe: multi-channel skid-buffered link pipeline with per-channel
// occupancy and delivered-flit counters. Each channel is an independent lane.

module enoc_link_lane #(
  parameter int WIDTH     = 64,
  parameter int STAGES    = 2,
  parameter int CNT_WIDTH = 32,
  parameter int OCC_W     = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     i_data,
  input  logic                 i_data_val,
  output logic                 o_en,
  output logic [WIDTH-1:0]     o_data,
  output logic                 o_data_val,
  input  logic                 i_en,
  input  logic                 i_clear,
  output logic [OCC_W-1:0]     o_occupancy,
  output logic [CNT_WIDTH-1:0] o_flit_count
);

  // vld_pipe[k] is the valid entering stage k; vld_pipe[STAGES] is the lane output.
  // rdy_pipe[k] is the enable stage k offers upstream; rdy_pipe[STAGES] is i_en.
  logic [STAGES:0]              vld_pipe;
  logic [STAGES:0]              rdy_pipe;
  logic [STAGES-1:0]            push, pop;
  logic [STAGES-1:0][1:0]       cnt;
  logic [STAGES-1:0][WIDTH-1:0] head, tail, din;

  // Handshake fabric between stages; enables come from counts only, so i_en
  // never reaches o_en combinationally.
  always_comb begin
    vld_pipe         = '0;
    rdy_pipe         = '0;
    din              = '0;
    vld_pipe[0]      = i_data_val;
    rdy_pipe[STAGES] = i_en;
    din[0]           = i_data;
    for (int k = 0; k < STAGES; k++) begin
      vld_pipe[k+1] = (cnt[k] != 2'd0);
      rdy_pipe[k]   = (cnt[k] != 2'd2);
    end
    for (int k = 1; k < STAGES; k++) din[k] = head[k-1];
    for (int k = 0; k < STAGES; k++) begin
      push[k] = vld_pipe[k]   & rdy_pipe[k];
      pop[k]  = vld_pipe[k+1] & rdy_pipe[k+1];
    end
  end

  // Per-stage 2-entry FIFO: head is the oldest entry, tail the skid slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      head <= '0;
      tail <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        case ({push[k], pop[k]})
          2'b10: begin
            if (cnt[k] == 2'd0) head[k] <= din[k];
            else                tail[k] <= din[k];
            cnt[k] <= cnt[k] + 2'd1;
          end
          2'b01: begin
            if (cnt[k] == 2'd2) head[k] <= tail[k];
            cnt[k] <= cnt[k] - 2'd1;
          end
          // Push and pop together only happens at count 1 (full stage refuses
          // pushes, empty stage cannot pop): data advances, count unchanged.
          2'b11: head[k] <= din[k];
          default: ;
        endcase
      end
    end
  end

  // Occupancy is the sum of the stage counts.
  always_comb begin
    o_occupancy = '0;
    for (int k = 0; k < STAGES; k++) o_occupancy = o_occupancy + OCC_W'(cnt[k]);
  end

  // Delivered-flit counter; clear beats a same-cycle delivery.
  always_ff @(posedge clk) begin
    if (reset || i_clear)             o_flit_count <= '0;
    else if (vld_pipe[STAGES] & i_en) o_flit_count <= o_flit_count + 1'b1;
  end

  assign o_en       = ~reset & rdy_pipe[0];
  assign o_data     = head[STAGES-1];
  assign o_data_val = vld_pipe[STAGES];

endmodule

module enoc_link_pipe #(
  parameter int WIDTH     = 64,
  parameter int CHANNELS  = 4,
  parameter int STAGES    = 2,
  parameter int CNT_WIDTH = 32
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic [CHANNELS-1:0][WIDTH-1:0]                 i_data,
  input  logic [CHANNELS-1:0]                            i_data_val,
  output logic [CHANNELS-1:0]                            o_en,
  output logic [CHANNELS-1:0][WIDTH-1:0]                 o_data,
  output logic [CHANNELS-1:0]                            o_data_val,
  input  logic [CHANNELS-1:0]                            i_en,
  input  logic                                           i_clear,
  output logic [CHANNELS-1:0][$clog2(2*STAGES+1)-1:0]    o_occupancy,
  output logic [CHANNELS-1:0][CNT_WIDTH-1:0]             o_flit_count
);

  localparam int OCC_W = $clog2(2*STAGES+1);

  if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
    $error("enoc_link_pipe: STAGES=%0d outside legal range 1..8", STAGES);
  end

  // One independent lane per channel.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    enoc_link_lane #(
      .WIDTH(WIDTH), .STAGES(STAGES), .CNT_WIDTH(CNT_WIDTH), .OCC_W(OCC_W)
    ) u_lane (
      .clk          (clk),
      .reset        (reset),
      .i_data       (i_data[c]),
      .i_data_val   (i_data_val[c]),
      .o_en         (o_en[c]),
      .o_data       (o_data[c]),
      .o_data_val   (o_data_val[c]),
      .i_en         (i_en[c]),
      .i_clear      (i_clear),
      .o_occupancy  (o_occupancy[c]),
      .o_flit_count (o_flit_count[c])
    );
  end

endmodule

// File: tb/tb_enoc_link_pipe.sv
// Bench for enoc_link_pipe: directed scenarios plus a randomized run checked
// against per-channel FIFO queues. A second instance with 4-bit counters
// exercises counter wrap.

module tb_enoc_link_pipe;

  localparam int WIDTH    = 64;
  localparam int CHANNELS = 4;
  localparam int STAGES   = 2;
  localparam int OCC_W    = $clog2(2*STAGES+1);
  localparam int DEPTH    = 2*STAGES;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [CHANNELS-1:0][WIDTH-1:0] i_data = '0;
  logic [CHANNELS-1:0]            i_data_val = '0;
  logic [CHANNELS-1:0]            i_en = '0;
  logic                           i_clear = 1'b0;

  logic [CHANNELS-1:0]            o_en, o_data_val, o_en4, o_data_val4;
  logic [CHANNELS-1:0][WIDTH-1:0] o_data, o_data4;
  logic [CHANNELS-1:0][OCC_W-1:0] o_occupancy, o_occupancy4;
  logic [CHANNELS-1:0][31:0]      o_flit_count;
  logic [CHANNELS-1:0][3:0]       o_flit_count4;

  int n_cmp = 0;
  int n_bad = 0;

  logic [WIDTH-1:0] sbq [CHANNELS][$];

  always #5 clk = ~clk;

  enoc_link_pipe #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .STAGES(STAGES), .CNT_WIDTH(32)) u_dut (
    .clk(clk), .reset(reset), .i_data(i_data), .i_data_val(i_data_val), .o_en(o_en),
    .o_data(o_data), .o_data_val(o_data_val), .i_en(i_en), .i_clear(i_clear),
    .o_occupancy(o_occupancy), .o_flit_count(o_flit_count));

  enoc_link_pipe #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .STAGES(STAGES), .CNT_WIDTH(4)) u_dut4 (
    .clk(clk), .reset(reset), .i_data(i_data), .i_data_val(i_data_val), .o_en(o_en4),
    .o_data(o_data4), .o_data_val(o_data_val4), .i_en(i_en), .i_clear(i_clear),
    .o_occupancy(o_occupancy4), .o_flit_count(o_flit_count4));

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; i_data_val = '0; i_en = '0; i_clear = 1'b0; i_data = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; i_data_val = '0; i_en = '0; i_clear = 1'b0; i_data = '0;
    repeat (2) @(negedge clk);
    n_cmp++; if (o_en !== '0) begin n_bad++; $display("FAIL reset_o_en: got %b want 0", o_en); end
    n_cmp++; if (o_data_val !== '0) begin n_bad++; $display("FAIL reset_val: got %b want 0", o_data_val); end
    n_cmp++; if (o_occupancy !== '0) begin n_bad++; $display("FAIL reset_occ: got %h want 0", o_occupancy); end
    n_cmp++; if (o_flit_count !== '0) begin n_bad++; $display("FAIL reset_cnt: got %h want 0", o_flit_count); end
    n_cmp++; if (o_data !== '0) begin n_bad++; $display("FAIL reset_data: got %h want 0", o_data); end
    reset = 1'b0;
    #1;
    n_cmp++; if (o_en !== '1) begin n_bad++; $display("FAIL reset_release_o_en: got %b want 1111", o_en); end
  endtask

  task automatic test_latency();
    i_en = '1;
    i_data[0] = 64'hA5; i_data_val = 4'b0001;
    @(negedge clk);
    i_data_val = '0;
    for (int i = 1; i < STAGES; i++) begin
      n_cmp++; if (o_data_val !== '0) begin n_bad++; $display("FAIL latency_early: cyc %0d got %b want 0000", i, o_data_val); end
      @(negedge clk);
    end
    n_cmp++; if (o_data_val !== 4'b0001) begin n_bad++; $display("FAIL latency_val: got %b want 0001", o_data_val); end
    n_cmp++; if (o_data[0] !== 64'hA5) begin n_bad++; $display("FAIL latency_data: got %h want a5", o_data[0]); end
    @(negedge clk);
    n_cmp++; if (o_data_val !== '0) begin n_bad++; $display("FAIL latency_after: got %b want 0000", o_data_val); end
    n_cmp++; if (o_flit_count[0] !== 32'd1) begin n_bad++; $display("FAIL latency_count: got %0d want 1", o_flit_count[0]); end
  endtask

  task automatic test_throughput();
    int got = 0;
    do_reset();
    i_en = '1;
    for (int cyc = 0; cyc < 100 + STAGES + 4; cyc++) begin
      @(negedge clk);
      if (o_data_val[1]) begin
        n_cmp++;
        if (o_data[1] !== 64'(got)) begin n_bad++; $display("FAIL tput_data: got %0d want %0d", o_data[1], got); end
        got++;
      end else if (got > 0 && got < 100) begin
        n_cmp++; n_bad++; $display("FAIL tput_gap: bubble after %0d outputs, want contiguous", got);
      end
      if (cyc < 100) begin
        i_data[1] = 64'(cyc); i_data_val = 4'b0010;
        #1;
        n_cmp++; if (o_en[1] !== 1'b1) begin n_bad++; $display("FAIL tput_o_en: cyc %0d got 0 want 1", cyc); end
      end else i_data_val = '0;
    end
    n_cmp++; if (got !== 100) begin n_bad++; $display("FAIL tput_total: got %0d want 100", got); end
    n_cmp++; if (o_flit_count[1] !== 32'd100) begin n_bad++; $display("FAIL tput_count: got %0d want 100", o_flit_count[1]); end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    int got = 0;
    i_en = 4'b1011;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      i_data[2] = 64'(1000 + acc); i_data_val = 4'b0100;
      #1;
      if (o_en[2]) acc++;
    end
    @(negedge clk);
    i_data_val = '0;
    n_cmp++; if (acc !== DEPTH) begin n_bad++; $display("FAIL bp_accepted: got %0d want %0d", acc, DEPTH); end
    n_cmp++; if (o_en[2] !== 1'b0) begin n_bad++; $display("FAIL bp_o_en_low: got 1 want 0"); end
    n_cmp++; if (o_occupancy[2] !== OCC_W'(DEPTH)) begin n_bad++; $display("FAIL bp_occ: got %0d want %0d", o_occupancy[2], DEPTH); end
    n_cmp++; if (o_data_val[2] !== 1'b1 || o_data[2] !== 64'd1000) begin n_bad++; $display("FAIL bp_head: got v%b %0d want v1 1000", o_data_val[2], o_data[2]); end
    i_en = '1;
    for (int cyc = 0; cyc < 20 && got < acc + 1; cyc++) begin
      if (o_data_val[2]) begin
        n_cmp++;
        if (o_data[2] !== 64'(1000 + got)) begin n_bad++; $display("FAIL bp_drain: got %0d want %0d", o_data[2], 1000 + got); end
        got++;
      end
      @(negedge clk);
    end
    n_cmp++; if (got !== DEPTH) begin n_bad++; $display("FAIL bp_drain_count: got %0d want %0d", got, DEPTH); end
    n_cmp++; if (o_en[2] !== 1'b1 || o_occupancy[2] !== '0) begin n_bad++; $display("FAIL bp_recover: o_en %b occ %0d want 1 0", o_en[2], o_occupancy[2]); end
  endtask

  task automatic test_random();
    int unsigned     deliv [CHANNELS];
    logic            stall [CHANNELS];
    logic [WIDTH-1:0] held [CHANNELS];
    do_reset();
    for (int c = 0; c < CHANNELS; c++) begin
      sbq[c].delete(); deliv[c] = 0; stall[c] = 1'b0; held[c] = '0;
    end
    for (int cyc = 0; cyc < 10000 + DEPTH + 4; cyc++) begin
      @(negedge clk);
      for (int c = 0; c < CHANNELS; c++) begin
        if (stall[c]) begin
          n_cmp++;
          if (o_data_val[c] !== 1'b1 || o_data[c] !== held[c]) begin
            n_bad++; $display("FAIL rnd_hold: ch%0d got v%b %h want v1 %h", c, o_data_val[c], o_data[c], held[c]);
          end
        end
        n_cmp++;
        if (o_occupancy[c] !== OCC_W'(sbq[c].size())) begin
          n_bad++; $display("FAIL rnd_occ: ch%0d cyc %0d got %0d want %0d", c, cyc, o_occupancy[c], sbq[c].size());
        end
        if (sbq[c].size() == DEPTH) begin
          n_cmp++;
          if (o_en[c] !== 1'b0) begin n_bad++; $display("FAIL rnd_full_o_en: ch%0d got 1 want 0", c); end
        end
      end
      for (int c = 0; c < CHANNELS; c++) begin
        if (cyc < 10000) begin
          i_data_val[c] = ($urandom_range(0, 99) < 60);
          i_en[c]       = ($urandom_range(0, 99) < 60);
          i_data[c]     = {$urandom, $urandom};
        end else begin
          i_data_val[c] = 1'b0; i_en[c] = 1'b1;
        end
      end
      #1;
      for (int c = 0; c < CHANNELS; c++) begin
        if (o_data_val[c] && i_en[c]) begin
          n_cmp++;
          if (sbq[c].size() == 0) begin
            n_bad++; $display("FAIL rnd_spurious: ch%0d got %h want nothing", c, o_data[c]);
          end else begin
            if (o_data[c] !== sbq[c][0]) begin
              n_bad++; $display("FAIL rnd_order: ch%0d got %h want %h", c, o_data[c], sbq[c][0]);
            end
            void'(sbq[c].pop_front());
          end
          deliv[c]++;
        end
        if (i_data_val[c] && o_en[c]) sbq[c].push_back(i_data[c]);
        stall[c] = o_data_val[c] && !i_en[c];
        held[c]  = o_data[c];
      end
    end
    @(negedge clk);
    for (int c = 0; c < CHANNELS; c++) begin
      n_cmp++; if (o_occupancy[c] !== '0) begin n_bad++; $display("FAIL rnd_final_occ: ch%0d got %0d want 0", c, o_occupancy[c]); end
      n_cmp++; if (o_flit_count[c] !== deliv[c]) begin n_bad++; $display("FAIL rnd_count: ch%0d got %0d want %0d", c, o_flit_count[c], deliv[c]); end
    end
  endtask

  task automatic test_reset_mid();
    int acc = 0;
    i_en = '0;
    for (int i = 0; i < 10 && acc < 3; i++) begin
      @(negedge clk);
      i_data[0] = 64'(256 + acc); i_data_val = 4'b0001;
      #1;
      if (o_en[0]) acc++;
    end
    @(negedge clk);
    i_data_val = '0;
    n_cmp++; if (o_occupancy[0] !== OCC_W'(3) || acc !== 3) begin n_bad++; $display("FAIL rmid_fill: occ %0d acc %0d want 3 3", o_occupancy[0], acc); end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (o_en !== '0) begin n_bad++; $display("FAIL rmid_o_en: got %b want 0000", o_en); end
    n_cmp++; if (o_data_val !== '0) begin n_bad++; $display("FAIL rmid_val: got %b want 0000", o_data_val); end
    n_cmp++; if (o_occupancy !== '0) begin n_bad++; $display("FAIL rmid_occ: got %h want 0", o_occupancy); end
    n_cmp++; if (o_flit_count !== '0) begin n_bad++; $display("FAIL rmid_cnt: got %h want 0", o_flit_count); end
    reset = 1'b0; i_en = '1;
    #1;
    n_cmp++; if (o_en !== '1) begin n_bad++; $display("FAIL rmid_release: got %b want 1111", o_en); end
    for (int i = 0; i < DEPTH + 2; i++) begin
      @(negedge clk);
      n_cmp++; if (o_data_val !== '0) begin n_bad++; $display("FAIL rmid_stale: got %b want 0000", o_data_val); end
    end
    i_data[0] = 64'h77; i_data_val = 4'b0001;
    @(negedge clk);
    i_data_val = '0;
    repeat (STAGES - 1) @(negedge clk);
    n_cmp++; if (o_data_val !== 4'b0001 || o_data[0] !== 64'h77) begin n_bad++; $display("FAIL rmid_fresh: got v%b %h want v0001 77", o_data_val, o_data[0]); end
    @(negedge clk);
    n_cmp++; if (o_flit_count[0] !== 32'd1) begin n_bad++; $display("FAIL rmid_fresh_cnt: got %0d want 1", o_flit_count[0]); end
  endtask

  task automatic test_counter();
    bit seen = 1'b0;
    do_reset();
    i_en = '1;
    for (int cyc = 0; cyc < 17 + STAGES + 3; cyc++) begin
      @(negedge clk);
      if (cyc < 17) begin i_data[3] = 64'(cyc); i_data_val = 4'b1000; end
      else i_data_val = '0;
    end
    @(negedge clk);
    n_cmp++; if (o_flit_count4[3] !== 4'(17 % 16)) begin n_bad++; $display("FAIL cnt_wrap: got %0d want %0d", o_flit_count4[3], 17 % 16); end
    n_cmp++; if (o_flit_count[3] !== 32'd17) begin n_bad++; $display("FAIL cnt_17: got %0d want 17", o_flit_count[3]); end
    i_data[3] = 64'h3C; i_data_val = 4'b1000;
    @(negedge clk);
    i_data_val = '0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (o_data_val[3]) seen = 1'b1;
      else @(negedge clk);
    end
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL cnt_clr_timeout: got no flit want one within 10 cycles"); end
    i_clear = 1'b1;
    @(negedge clk);
    i_clear = 1'b0;
    n_cmp++; if (o_flit_count4[3] !== 4'd0 || o_flit_count[3] !== 32'd0) begin n_bad++; $display("FAIL cnt_clear_wins: got %0d/%0d want 0/0", o_flit_count4[3], o_flit_count[3]); end
    n_cmp++; if (o_data_val[3] !== 1'b0) begin n_bad++; $display("FAIL cnt_clr_delivered: got 1 want 0"); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_throughput();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_counter();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
